// File: rtl/xpb_accum.sv
// Folds NIBBLES high nibbles of a square fragment into the low part, one LUT residue per cycle.
// Result appears NIBBLES+1 cycles after accept. One operand in flight; no new accept until the result is taken.
module xpb_accum #(
  parameter int NIBBLES = 4,
  parameter int LOW_W   = 1020,
  parameter int OUT_W   = 1027
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LOW_W+4*NIBBLES-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [2:0]                 xpb_pos,
  output logic [3:0]                 xpb_sel,
  input  logic [1023:0]              xpb_data,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_cnt;
  logic [31:0]      r_hold;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_sum;
  logic             w_last;

  assign w_last   = (r_cnt == 3'(NIBBLES - 1));
  assign w_sum    = r_acc + {{(OUT_W-1024){1'b0}}, xpb_data};
  assign out_data = r_out;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    xpb_pos     = 3'd0;
    xpb_sel     = 4'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        // LUT select comes from registers only, keeping xpb_data off any input-to-output path
        xpb_pos = r_cnt;
        xpb_sel = r_hold[{r_cnt, 2'b00} +: 4];
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_hold  <= 32'd0;
      r_acc   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && in_valid) begin
        r_hold <= 32'(in_data[LOW_W +: 4*NIBBLES]);
        r_acc  <= OUT_W'(in_data[LOW_W-1:0]);
        r_cnt  <= 3'd0;
      end else if (r_state == S_ACCUM) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 3'd1;
        // separate output register so out_data only moves when DONE is entered
        if (w_last) r_out <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_xpb_accum.sv
// Directed and randomized bench for xpb_accum with a behavioural LUT and an in-order result scoreboard.
module tb_xpb_accum;
  localparam int NIBBLES = 4;
  localparam int LOW_W   = 1020;
  localparam int OUT_W   = 1027;
  localparam int IN_W    = LOW_W + 4*NIBBLES;
  localparam logic [1039:0] MODULUS = (1040'd1 << 1024) - 1040'd189;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       xpb_pos;
  logic [3:0]       xpb_sel;
  logic [1023:0]    xpb_data;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  int n_cmp = 0;
  int n_mis = 0;
  logic [OUT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  xpb_accum #(.NIBBLES(NIBBLES), .LOW_W(LOW_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .xpb_pos(xpb_pos), .xpb_sel(xpb_sel), .xpb_data(xpb_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [1023:0] xpb(input int k, input logic [3:0] v);
    logic [1039:0] t;
    t = 1040'(v) << (LOW_W + 4*k);
    return 1024'(t % MODULUS);
  endfunction

  always_comb xpb_data = xpb(int'(xpb_pos), xpb_sel);

  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] acc;
    acc = OUT_W'(d[LOW_W-1:0]);
    for (int k = 0; k < NIBBLES; k++)
      acc = acc + OUT_W'(xpb(k, d[LOW_W+4*k +: 4]));
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [1039:0] obs, input logic [1039:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h..%h expected=%h..%h", tag,
             obs[1039:976], obs[127:0], exp[1039:976], exp[127:0]);
    end
  endtask

  // Returns at the negedge following the accepting posedge, with in_valid dropped.
  task automatic send(input logic [IN_W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 1040'(in_ready), 1040'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) exp_q.push_back(model(d));
  endtask

  task automatic recv(input int stall);
    bit ok;
    logic [OUT_W-1:0] exp;
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("result_timeout", 1040'(out_valid), 1040'(1));
    else if (exp_q.size() == 0) chk("unexpected_result", 1040'(out_valid), 1040'(0));
    else begin
      exp = exp_q.pop_front();
      chk("out_data", 1040'(out_data), 1040'(exp));
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [IN_W-1:0]  d;
    logic [OUT_W-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  1040'(in_ready), 1040'(1));
    chk("rst_out_valid", 1040'(out_valid), 1040'(0));
    chk("rst_out_data",  1040'(out_data), 1040'(0));
    chk("rst_xpb_pos",   1040'(xpb_pos), 1040'(0));
    chk("rst_xpb_sel",   1040'(xpb_sel), 1040'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // zero nibbles: fixed latency, select stays zero
    d = '0; d[15:0] = 16'h1234;
    send(d);
    for (int k = 0; k < NIBBLES; k++) begin
      chk("t1_pos", 1040'(xpb_pos), 1040'(k));
      chk("t1_sel", 1040'(xpb_sel), 1040'(0));
      chk("t1_not_yet_valid", 1040'(out_valid), 1040'(0));
      chk("t1_in_ready_busy", 1040'(in_ready), 1040'(0));
      @(negedge clk);
    end
    chk("t1_latency_valid", 1040'(out_valid), 1040'(1));
    chk("t1_value", 1040'(out_data), 1040'(16'h1234));
    recv(0);

    // single nibble0 = 1
    d = '0; d[LOW_W] = 1'b1;
    send(d);
    for (int k = 0; k < NIBBLES; k++) begin
      chk("t2_pos", 1040'(xpb_pos), 1040'(k));
      chk("t2_sel", 1040'(xpb_sel), 1040'((k == 0) ? 1 : 0));
      @(negedge clk);
    end
    chk("t2_value", 1040'(out_data), 1040'(xpb(0, 4'd1)));
    recv(0);

    // maximum operand: no truncation of the top accumulator bits
    d = '1;
    send(d);
    recv(0);

    // DONE held by backpressure; in_valid pulse must be ignored
    d = '0; d[7:0] = 8'h77; d[LOW_W+4 +: 4] = 4'h9;
    send(d);
    repeat (NIBBLES) @(negedge clk);
    held = out_data;
    chk("t4_done_valid", 1040'(out_valid), 1040'(1));
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_data = '1; in_valid = 1'b1; end
      if (c == 4) in_valid = 1'b0;
      @(negedge clk);
      chk("t4_stable_data", 1040'(out_data), 1040'(held));
      chk("t4_stable_valid", 1040'(out_valid), 1040'(1));
      chk("t4_in_ready_low", 1040'(in_ready), 1040'(0));
    end
    chk("t4_value", 1040'(held), 1040'(exp_q.pop_front()));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_back_idle_ready", 1040'(in_ready), 1040'(1));
    chk("t4_back_idle_valid", 1040'(out_valid), 1040'(0));
    @(negedge clk);
    chk("t4_pulse_not_taken", 1040'(in_ready), 1040'(1));

    // reset during the 2nd ACCUM cycle
    d = '1;
    send(d);
    @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", 1040'(out_valid), 1040'(0));
    chk("t5_in_ready", 1040'(in_ready), 1040'(1));
    d = '0; d[3:0] = 4'h5;
    send(d);
    recv(0);
    chk("t5_value_5", 1040'(out_data), 1040'(5));

    // random operands with random result stalls
    for (int n = 0; n < 100; n++) begin
      for (int w = 0; w < (IN_W + 31) / 32; w++)
        d[w*32 +: 32] = (w*32 + 32 <= IN_W) ? $urandom() : 32'($urandom_range(0, 4095));
      if (n % 10 == 0) d[LOW_W +: 4*NIBBLES] = '0;
      send(d);
      recv($urandom_range(0, 12));
    end
    chk("scoreboard_empty", 1040'(exp_q.size()), 1040'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
